llc_reply_collector: RTL and testbench

Merges the four per-port LLC reply channels produced by `llc_proxy` (`llc_si_r` / `llc_ri_r` / `llc_di_r`) into one reply stream, tagging each reply with its source port. It sits directly downstream of `llc_proxy`. It grants one port per cycle using round-robin arbitration, buffers replies in a DEPTH-entry FIFO, and presents them on a single valid/ready output.

---
 rtl/llc_reply_collector.sv | 129 ++++++++++++
 tb/tb_llc_reply_collector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/llc_reply_collector.sv
// Merges four per-port LLC reply channels into one tagged stream: round-robin grant
// into a DEPTH-entry FIFO, drained through a single valid/ready output.
module llc_reply_collector #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [3:0]                rep_si,
   output logic [3:0]                rep_ri,
   input  logic [4*DATA_W-1:0]       rep_di,
   output logic                      out_so,
   input  logic                      out_ro,
   output logic [DATA_W-1:0]         out_do,
   output logic [1:0]                out_src,
   output logic [$clog2(DEPTH):0]    occ,
   output logic [15:0]               acc_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [1:0]        src_mem  [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic [PTR_W:0]    count_next;
   logic [1:0]        rr_ptr_reg;
   logic [15:0]       acc_cnt_reg;

   logic [DATA_W-1:0] rep_data [4];
   logic [3:0]        rot_req;
   logic [1:0]        grant_off;
   logic [1:0]        grant_idx;
   logic              grant_valid;
   logic              enq;
   logic              deq;

   // rot_req[k] is the request of port rr_ptr+k, so the lowest set bit wins.
   for (genvar gi = 0; gi < 4; gi++) begin : g_port
      assign rep_data[gi] = rep_di[DATA_W*gi +: DATA_W];
      assign rot_req[gi]  = rep_si[rr_ptr_reg + 2'(gi)];
   end

   always_comb begin
      grant_off   = 2'd0;
      grant_valid = 1'b0;
      if (!reset && (count_reg != FULL_CNT)) begin
         if (rot_req[0]) begin
            grant_off   = 2'd0;
            grant_valid = 1'b1;
         end else if (rot_req[1]) begin
            grant_off   = 2'd1;
            grant_valid = 1'b1;
         end else if (rot_req[2]) begin
            grant_off   = 2'd2;
            grant_valid = 1'b1;
         end else if (rot_req[3]) begin
            grant_off   = 2'd3;
            grant_valid = 1'b1;
         end
      end
   end

   assign grant_idx = rr_ptr_reg + grant_off;

   always_comb begin
      rep_ri = 4'b0000;
      if (grant_valid) begin
         rep_ri[grant_idx] = 1'b1;
      end
   end

   // A grant always coincides with the granted port's valid, so it is the enqueue.
   assign enq = grant_valid;
   assign deq = (count_reg != '0) && out_ro;

   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
         2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            src_mem[i]  <= '0;
         end
      end else if (enq) begin
         data_mem[wr_ptr_reg] <= rep_data[grant_idx];
         src_mem[wr_ptr_reg]  <= grant_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         rr_ptr_reg  <= '0;
         acc_cnt_reg <= '0;
      end else begin
         count_reg <= count_next;
         if (enq) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            rr_ptr_reg <= grant_idx + 2'd1;
            if (acc_cnt_reg != 16'hFFFF) begin
               acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
         end
         if (deq) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   assign out_so  = (count_reg != '0);
   assign out_do  = data_mem[rd_ptr_reg];
   assign out_src = src_mem[rd_ptr_reg];
   assign occ     = count_reg;
   assign acc_cnt = acc_cnt_reg;

endmodule

// File: tb/tb_llc_reply_collector.sv
// Directed vector bench for llc_reply_collector: each vector drives inputs, checks the
// pre-edge outputs, then clocks once. Hand-written sequence covers mid-cycle reset.
module tb_llc_reply_collector;

   localparam int DATA_W = 64;
   localparam int DEPTH  = 4;
   localparam logic [55:0] BASE = 56'hABCD55AA133700;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [3:0]           rep_si = 4'b0;
   logic [3:0]           rep_ri;
   logic [4*DATA_W-1:0]  rep_di = '0;
   logic                 out_so;
   logic                 out_ro = 1'b0;
   logic [DATA_W-1:0]    out_do;
   logic [1:0]           out_src;
   logic [2:0]           occ;
   logic [15:0]          acc_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   llc_reply_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .rep_si  (rep_si),
      .rep_ri  (rep_ri),
      .rep_di  (rep_di),
      .out_so  (out_so),
      .out_ro  (out_ro),
      .out_do  (out_do),
      .out_src (out_src),
      .occ     (occ),
      .acc_cnt (acc_cnt)
   );

   typedef struct {
      logic        rst_before;
      logic [3:0]  si;
      logic [31:0] tags;      // port i tag in [8i+7:8i]
      logic        ro;
      logic [3:0]  exp_ri;
      logic        exp_so;
      logic [1:0]  exp_src;
      logic [7:0]  exp_tag;
      logic [2:0]  exp_occ;
      logic [15:0] exp_acc;
   } vec_t;

   vec_t vecs[$];

   function automatic void vadd(input logic rb, input logic [3:0] si, input logic [31:0] tags,
                                input logic ro, input logic [3:0] ri, input logic so,
                                input logic [1:0] src, input logic [7:0] tag,
                                input logic [2:0] o, input logic [15:0] a);
      vec_t v;
      v.rst_before = rb; v.si = si; v.tags = tags; v.ro = ro; v.exp_ri = ri;
      v.exp_so = so; v.exp_src = src; v.exp_tag = tag; v.exp_occ = o; v.exp_acc = a;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] si, input logic [31:0] tags, input logic ro);
      rep_si = si;
      out_ro = ro;
      for (int i = 0; i < 4; i++) begin
         rep_di[DATA_W*i +: DATA_W] = {BASE, tags[8*i +: 8]};
      end
   endtask

   task automatic do_reset();
      drive(4'b0, 32'h0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      // Single reply on port 2
      vadd(1, 4'b0100, 32'h00C20000, 0, 4'b0100, 0, 0, 8'h00, 0, 0);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 2, 8'hC2, 1, 1);
      vadd(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 0, 8'h00, 0, 1);
      // Round-robin: all four valid, each drops after its grant
      vadd(1, 4'b1111, 32'h13121110, 1, 4'b0001, 0, 0, 8'h00, 0, 0);
      vadd(0, 4'b1110, 32'h13121100, 1, 4'b0010, 1, 0, 8'h10, 1, 1);
      vadd(0, 4'b1100, 32'h13120000, 1, 4'b0100, 1, 1, 8'h11, 1, 2);
      vadd(0, 4'b1000, 32'h13000000, 1, 4'b1000, 1, 2, 8'h12, 1, 3);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 3, 8'h13, 1, 4);
      vadd(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 0, 8'h00, 0, 4);
      // Fairness: ports 0 and 3 continuously valid
      vadd(0, 4'b1001, 32'h30000020, 1, 4'b0001, 0, 0, 8'h00, 0, 4);
      vadd(0, 4'b1001, 32'h30000021, 1, 4'b1000, 1, 0, 8'h20, 1, 5);
      vadd(0, 4'b1001, 32'h31000021, 1, 4'b0001, 1, 3, 8'h30, 1, 6);
      vadd(0, 4'b1001, 32'h31000022, 1, 4'b1000, 1, 0, 8'h21, 1, 7);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 3, 8'h31, 1, 8);
      vadd(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 0, 8'h00, 0, 8);
      // Full, no pass-through, wrap order
      vadd(1, 4'b1111, 32'h43424140, 0, 4'b0001, 0, 0, 8'h00, 0, 0);
      vadd(0, 4'b1110, 32'h43424100, 0, 4'b0010, 1, 0, 8'h40, 1, 1);
      vadd(0, 4'b1100, 32'h43420000, 0, 4'b0100, 1, 0, 8'h40, 2, 2);
      vadd(0, 4'b1001, 32'h43000044, 0, 4'b1000, 1, 0, 8'h40, 3, 3);
      vadd(0, 4'b0001, 32'h00000044, 0, 4'b0000, 1, 0, 8'h40, 4, 4);
      vadd(0, 4'b0001, 32'h00000044, 1, 4'b0000, 1, 0, 8'h40, 4, 4);
      vadd(0, 4'b0001, 32'h00000044, 0, 4'b0001, 1, 1, 8'h41, 3, 4);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 1, 8'h41, 4, 5);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 2, 8'h42, 3, 5);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 3, 8'h43, 2, 5);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 0, 8'h44, 1, 5);
      vadd(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 0, 8'h00, 0, 5);
      // Simultaneous enqueue and dequeue at occ = 2
      vadd(0, 4'b0010, 32'h00005000, 0, 4'b0010, 0, 0, 8'h00, 0, 5);
      vadd(0, 4'b0100, 32'h00510000, 0, 4'b0100, 1, 1, 8'h50, 1, 6);
      vadd(0, 4'b1000, 32'h52000000, 1, 4'b1000, 1, 1, 8'h50, 2, 7);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 2, 8'h51, 2, 8);
      vadd(0, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 3, 8'h52, 1, 8);
      vadd(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 0, 8'h00, 0, 8);

      do_reset();
      #1;
      chk("reset out_so", 64'(out_so), 64'd0);
      chk("reset occ", 64'(occ), 64'd0);
      chk("reset acc_cnt", 64'(acc_cnt), 64'd0);
      chk("reset out_do", out_do, 64'd0);
      chk("reset rep_ri", 64'(rep_ri), 64'd0);

      for (int v = 0; v < vecs.size(); v++) begin
         if (vecs[v].rst_before) do_reset();
         drive(vecs[v].si, vecs[v].tags, vecs[v].ro);
         #1;
         $display("vec %0d: si=%b ro=%b ri=%b so=%b src=%0d do=%h occ=%0d acc=%0d",
                  v, rep_si, out_ro, rep_ri, out_so, out_src, out_do, occ, acc_cnt);
         chk($sformatf("vec%0d rep_ri", v), 64'(rep_ri), 64'(vecs[v].exp_ri));
         chk($sformatf("vec%0d out_so", v), 64'(out_so), 64'(vecs[v].exp_so));
         chk($sformatf("vec%0d occ", v), 64'(occ), 64'(vecs[v].exp_occ));
         chk($sformatf("vec%0d acc_cnt", v), 64'(acc_cnt), 64'(vecs[v].exp_acc));
         if (vecs[v].exp_so) begin
            chk($sformatf("vec%0d out_src", v), 64'(out_src), 64'(vecs[v].exp_src));
            chk($sformatf("vec%0d out_do", v), out_do, {BASE, vecs[v].exp_tag});
         end
         @(posedge clk);
         #1;
      end

      // Mid-operation reset with three entries buffered
      do_reset();
      drive(4'b0001, 32'h00000060, 1'b0);
      @(posedge clk); #1;
      drive(4'b0010, 32'h00006100, 1'b0);
      @(posedge clk); #1;
      drive(4'b0100, 32'h00620000, 1'b0);
      @(posedge clk); #1;
      drive(4'b0010, 32'h00006300, 1'b0);
      #1;
      $display("mid-reset pre: ri=%b so=%b occ=%0d acc=%0d", rep_ri, out_so, occ, acc_cnt);
      chk("pre-reset occ", 64'(occ), 64'd3);
      chk("pre-reset acc_cnt", 64'(acc_cnt), 64'd3);
      chk("pre-reset rep_ri", 64'(rep_ri), 64'b0010);
      #2 reset = 1'b1;
      #1;
      $display("mid-reset in: ri=%b so=%b occ=%0d acc=%0d do=%h", rep_ri, out_so, occ, acc_cnt, out_do);
      chk("async reset out_so", 64'(out_so), 64'd0);
      chk("async reset rep_ri", 64'(rep_ri), 64'd0);
      chk("async reset occ", 64'(occ), 64'd0);
      chk("async reset acc_cnt", 64'(acc_cnt), 64'd0);
      chk("async reset out_do", out_do, 64'd0);
      chk("async reset out_src", 64'(out_src), 64'd0);
      #2 reset = 1'b0;
      drive(4'b1010, 32'h65006400, 1'b0);
      #1;
      chk("post-reset grant", 64'(rep_ri), 64'b0010);
      @(posedge clk); #1;
      drive(4'b0000, 32'h0, 1'b0);
      #1;
      $display("mid-reset post: so=%b src=%0d do=%h occ=%0d acc=%0d", out_so, out_src, out_do, occ, acc_cnt);
      chk("post-reset out_src", 64'(out_src), 64'd1);
      chk("post-reset out_do", out_do, {BASE, 8'h64});
      chk("post-reset occ", 64'(occ), 64'd1);
      chk("post-reset acc_cnt", 64'(acc_cnt), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
